// File: rtl/voice_alloc.sv
// Polyphonic voice scheduler: MIDI note events -> per-voice on/off strobes.
// Optional VOICE_STEAL_EN enables oldest-voice stealing and per-voice ages.
module voice_alloc #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_BITS   = 8,
    parameter int MIDI_BYTES = 24
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [MIDI_BYTES-1:0] midi_event,
    input  logic [NUM_VOICES-1:0] voice_active_in,
    output logic [NUM_VOICES-1:0] voice_on_out,
    output logic [NUM_VOICES-1:0] voice_off_out,
    output logic [7:0]            voice_pitch_out,
    output logic [6:0]            voice_vel_out,
    output logic [NUM_VOICES-1:0] held_out,
    output logic [MIDI_BYTES-1:0] ctrl_event_out,
    output logic                  ctrl_valid_out,
    output logic                  steal_out,
    output logic                  drop_out
);

    localparam int IW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

    state_t                state;
    logic [MIDI_BYTES-1:0] prev_event, work, skid;
    logic                  skid_valid;
    logic [7:0]            pitch [NUM_VOICES];
    logic [IW-1:0]         idx;
    logic                  rt_found, fr_found;
    logic [IW-1:0]         rt_idx, fr_idx;
    logic                  n_rt_found, n_fr_found;
    logic [IW-1:0]         n_rt_idx, n_fr_idx;
    logic [IW-1:0]         sel;
    logic                  sel_ok;
    logic [NUM_VOICES-1:0] off_mask;
    logic                  new_ev, note_new, last;
`ifdef VOICE_STEAL_EN
    logic [AGE_BITS-1:0]   age [NUM_VOICES];
    logic [AGE_BITS-1:0]   best_age, n_best_age;
    logic [IW-1:0]         best_idx, n_best_idx;
    logic                  stolen;
`endif

    function automatic logic is_on(input logic [MIDI_BYTES-1:0] ev);
        return ev[23:16] == 8'h90 && ev[7:0] != 8'h00;
    endfunction

    function automatic logic is_off(input logic [MIDI_BYTES-1:0] ev);
        return ev[23:16] == 8'h80 || (ev[23:16] == 8'h90 && ev[7:0] == 8'h00);
    endfunction

    assign new_ev   = midi_event != prev_event;
    assign note_new = new_ev && (is_on(midi_event) || is_off(midi_event));
    assign last     = idx == IW'(NUM_VOICES - 1);

    // Fold the voice visited this cycle into the running scan result.
    always_comb begin
        n_rt_found = rt_found;
        n_rt_idx   = rt_idx;
        n_fr_found = fr_found;
        n_fr_idx   = fr_idx;
        if (!rt_found && pitch[idx] == work[15:8]
            && (held_out[idx] || voice_active_in[idx])) begin
            n_rt_found = 1'b1;
            n_rt_idx   = idx;
        end
        if (!fr_found && !voice_active_in[idx] && !held_out[idx]) begin
            n_fr_found = 1'b1;
            n_fr_idx   = idx;
        end
`ifdef VOICE_STEAL_EN
        n_best_idx = best_idx;
        n_best_age = best_age;
        if (idx == '0 || age[idx] > best_age) begin
            n_best_idx = idx;
            n_best_age = age[idx];
        end
`endif
    end

    always_comb begin
        sel    = '0;
        sel_ok = 1'b1;
`ifdef VOICE_STEAL_EN
        stolen = 1'b0;
`endif
        if (n_rt_found) begin
            sel = n_rt_idx;
        end else if (n_fr_found) begin
            sel = n_fr_idx;
        end else begin
`ifdef VOICE_STEAL_EN
            sel    = n_best_idx;
            stolen = 1'b1;
`else
            sel_ok = 1'b0;
`endif
        end
    end

    always_comb begin
        off_mask = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            off_mask[i] = held_out[i] && pitch[i] == work[15:8];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            prev_event      <= '0;
            work            <= '0;
            skid            <= '0;
            skid_valid      <= 1'b0;
            idx             <= '0;
            rt_found        <= 1'b0;
            fr_found        <= 1'b0;
            rt_idx          <= '0;
            fr_idx          <= '0;
            held_out        <= '0;
            voice_on_out    <= '0;
            voice_off_out   <= '0;
            voice_pitch_out <= '0;
            voice_vel_out   <= '0;
            ctrl_event_out  <= '0;
            ctrl_valid_out  <= 1'b0;
            steal_out       <= 1'b0;
            drop_out        <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) pitch[i] <= '0;
`ifdef VOICE_STEAL_EN
            best_age <= '0;
            best_idx <= '0;
            for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
`endif
        end else begin
            prev_event     <= midi_event;
            ctrl_valid_out <= new_ev && !note_new;
            if (new_ev && !note_new) ctrl_event_out <= midi_event;
            voice_on_out  <= '0;
            voice_off_out <= '0;
            steal_out     <= 1'b0;
            drop_out      <= 1'b0;
            // Skid capture is shared by SCAN and ISSUE; a full skid drops.
            if (note_new && state != IDLE) begin
                if (skid_valid) begin
                    drop_out <= 1'b1;
                end else if (state == SCAN) begin
                    skid       <= midi_event;
                    skid_valid <= 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (note_new) begin
                        work     <= midi_event;
                        idx      <= '0;
                        rt_found <= 1'b0;
                        fr_found <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    rt_found <= n_rt_found;
                    rt_idx   <= n_rt_idx;
                    fr_found <= n_fr_found;
                    fr_idx   <= n_fr_idx;
`ifdef VOICE_STEAL_EN
                    best_age <= n_best_age;
                    best_idx <= n_best_idx;
`endif
                    idx <= idx + 1'b1;
                    if (last) begin
                        state           <= ISSUE;
                        voice_pitch_out <= work[15:8];
                        if (is_on(work)) begin
                            if (sel_ok) begin
                                voice_on_out  <= NUM_VOICES'(1) << sel;
                                voice_vel_out <= work[6:0];
                                pitch[sel]    <= work[15:8];
                                held_out[sel] <= 1'b1;
`ifdef VOICE_STEAL_EN
                                steal_out <= stolen;
                                for (int i = 0; i < NUM_VOICES; i++) begin
                                    if (IW'(i) == sel) age[i] <= '0;
                                    else if (age[i] != '1) age[i] <= age[i] + 1'b1;
                                end
`endif
                            end else begin
                                drop_out <= 1'b1;
                            end
                        end else begin
                            voice_off_out <= off_mask;
                            held_out      <= held_out & ~off_mask;
                        end
                    end
                end
                ISSUE: begin
                    idx      <= '0;
                    rt_found <= 1'b0;
                    fr_found <= 1'b0;
                    if (skid_valid) begin
                        work       <= skid;
                        skid_valid <= 1'b0;
                        state      <= SCAN;
                    end else if (note_new) begin
                        work  <= midi_event;
                        state <= SCAN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench for voice_alloc against a behavioural voice model.
module tb_voice_alloc;

    localparam int NV = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [23:0]   midi_event = '0;
    logic [NV-1:0] act = '0;
    logic [NV-1:0] voice_on, voice_off, held;
    logic [7:0]    v_pitch;
    logic [6:0]    v_vel;
    logic [23:0]   ctrl_event;
    logic          ctrl_valid, steal, drop;

    int n_checks = 0;
    int n_fail   = 0;

    int m_pitch [NV];
    int m_age   [NV];
    bit m_held  [NV];

    voice_alloc #(.NUM_VOICES(NV), .AGE_BITS(8), .MIDI_BYTES(24)) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .midi_event(midi_event),
        .voice_active_in(act),
        .voice_on_out(voice_on),
        .voice_off_out(voice_off),
        .voice_pitch_out(v_pitch),
        .voice_vel_out(v_vel),
        .held_out(held),
        .ctrl_event_out(ctrl_event),
        .ctrl_valid_out(ctrl_valid),
        .steal_out(steal),
        .drop_out(drop)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_pitch[i] = 0;
            m_age[i]   = 0;
            m_held[i]  = 0;
        end
    endtask

    function automatic logic [NV-1:0] m_held_vec();
        logic [NV-1:0] v;
        for (int i = 0; i < NV; i++) v[i] = m_held[i];
        return v;
    endfunction

    // Apply one note event to the model, returning the expected strobes.
    task automatic predict(input logic [23:0] ev, input logic [NV-1:0] a,
                           output logic [NV-1:0] e_on, output logic [NV-1:0] e_off,
                           output logic e_steal, output logic e_drop);
        int p, d2, st, sel, best;
        st = int'(ev[23:16]);
        p  = int'(ev[15:8]);
        d2 = int'(ev[7:0]);
        e_on = '0; e_off = '0; e_steal = 0; e_drop = 0;
        if (st == 'h90 && d2 != 0) begin
            sel = -1;
            for (int i = 0; i < NV; i++)
                if (sel < 0 && m_pitch[i] == p && (m_held[i] || a[i])) sel = i;
            for (int i = 0; i < NV; i++)
                if (sel < 0 && !a[i] && !m_held[i]) sel = i;
            if (sel < 0) begin
`ifdef VOICE_STEAL_EN
                best = 0;
                for (int i = 1; i < NV; i++) if (m_age[i] > m_age[best]) best = i;
                sel = best;
                e_steal = 1;
`else
                e_drop = 1;
`endif
            end
            if (sel >= 0) begin
                e_on[sel] = 1'b1;
                m_pitch[sel] = p;
                m_held[sel] = 1;
                for (int i = 0; i < NV; i++)
                    if (i == sel) m_age[i] = 0;
                    else if (m_age[i] < 255) m_age[i]++;
            end
        end else if (st == 'h80 || st == 'h90) begin
            for (int i = 0; i < NV; i++)
                if (m_held[i] && m_pitch[i] == p) begin
                    e_off[i] = 1'b1;
                    m_held[i] = 0;
                end
        end
    endtask

    task automatic do_note(input logic [23:0] ev, input logic [NV-1:0] a, input string name);
        logic [NV-1:0] e_on, e_off;
        logic e_steal, e_drop;
        @(negedge clk);
        midi_event = ev;
        act = a;
        predict(ev, a, e_on, e_off, e_steal, e_drop);
        repeat (4) @(negedge clk);
        n_checks++;
        if (voice_on !== '0) begin
            n_fail++;
            $display("FAIL %s early: voice_on got %b want 0000", name, voice_on);
        end
        @(negedge clk);
        n_checks++;
        if (voice_on !== e_on) begin
            n_fail++;
            $display("FAIL %s on: got %b want %b", name, voice_on, e_on);
        end
        n_checks++;
        if (voice_off !== e_off) begin
            n_fail++;
            $display("FAIL %s off: got %b want %b", name, voice_off, e_off);
        end
        n_checks++;
        if (steal !== e_steal || drop !== e_drop) begin
            n_fail++;
            $display("FAIL %s steal/drop: got %b/%b want %b/%b", name, steal, drop, e_steal, e_drop);
        end
        n_checks++;
        if (held !== m_held_vec()) begin
            n_fail++;
            $display("FAIL %s held: got %b want %b", name, held, m_held_vec());
        end
        if (e_on != '0 || e_off != '0) begin
            n_checks++;
            if (v_pitch !== ev[15:8]) begin
                n_fail++;
                $display("FAIL %s pitch: got %h want %h", name, v_pitch, ev[15:8]);
            end
        end
        if (e_on != '0) begin
            n_checks++;
            if (v_vel !== ev[6:0]) begin
                n_fail++;
                $display("FAIL %s vel: got %h want %h", name, v_vel, ev[6:0]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (voice_on !== '0 || voice_off !== '0) begin
            n_fail++;
            $display("FAIL %s width: on %b off %b want 0", name, voice_on, voice_off);
        end
    endtask

    task automatic dut_reset();
        @(negedge clk);
        rst_n = 1'b0;
        midi_event = '0;
        act = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({voice_on, voice_off, v_pitch, v_vel, held, ctrl_event, ctrl_valid, steal, drop} !== '0) begin
            n_fail++;
            $display("FAIL reset: outputs got %h want 0",
                     {voice_on, voice_off, v_pitch, v_vel, held, ctrl_event, ctrl_valid, steal, drop});
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_first_note();
        do_note(24'h903C64, 4'b0000, "first_note");
    endtask

    task automatic test_note_off();
        do_note(24'h803C00, 4'b0000, "off_80");
        do_note(24'h903C64, 4'b0000, "reon");
        do_note(24'h903C00, 4'b0000, "off_vel0");
        do_note(24'h803D00, 4'b0000, "off_nomatch");
    endtask

    task automatic test_steal();
        dut_reset();
        do_note(24'h903C64, 4'b0000, "fill0");
        do_note(24'h904064, 4'b0000, "fill1");
        do_note(24'h904364, 4'b0000, "fill2");
        do_note(24'h904864, 4'b0000, "fill3");
        do_note(24'h904A50, 4'b1111, "steal");
    endtask

    task automatic test_ctrl();
        logic [NV-1:0] e_on, e_off;
        logic e_steal, e_drop;
        @(negedge clk);
        midi_event = 24'hB00140;
        @(negedge clk);
        n_checks++;
        if (ctrl_valid !== 1'b1 || ctrl_event !== 24'hB00140) begin
            n_fail++;
            $display("FAIL ctrl_idle: valid %b event %h want 1 B00140", ctrl_valid, ctrl_event);
        end
        @(negedge clk);
        n_checks++;
        if (ctrl_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ctrl_pulse: valid got %b want 0", ctrl_valid);
        end
        midi_event = 24'h904F22;
        act = '0;
        predict(24'h904F22, 4'b0000, e_on, e_off, e_steal, e_drop);
        repeat (2) @(negedge clk);
        midi_event = 24'hB07F10;
        @(negedge clk);
        n_checks++;
        if (ctrl_valid !== 1'b1 || ctrl_event !== 24'hB07F10) begin
            n_fail++;
            $display("FAIL ctrl_scan: valid %b event %h want 1 B07F10", ctrl_valid, ctrl_event);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (voice_on !== e_on) begin
            n_fail++;
            $display("FAIL ctrl_scan_note: on got %b want %b", voice_on, e_on);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [NV-1:0] e_on1, e_on2, e_off;
        logic e_steal, e_drop;
        dut_reset();
        @(negedge clk);
        midi_event = 24'h903C64;
        predict(24'h903C64, 4'b0000, e_on1, e_off, e_steal, e_drop);
        @(negedge clk);
        midi_event = 24'h904050;
        predict(24'h904050, 4'b0000, e_on2, e_off, e_steal, e_drop);
        @(negedge clk);
        midi_event = 24'h904370;
        for (int j = 3; j < 12; j++) begin
            @(negedge clk);
            n_checks++;
            if (j == 3) begin
                if (drop !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_drop: got %b want 1", drop);
                end
            end else if (j == 5) begin
                if (voice_on !== e_on1) begin
                    n_fail++;
                    $display("FAIL b2b_first: on got %b want %b", voice_on, e_on1);
                end
            end else if (j == 10) begin
                if (voice_on !== e_on2) begin
                    n_fail++;
                    $display("FAIL b2b_second: on got %b want %b", voice_on, e_on2);
                end
            end else if (voice_on !== '0) begin
                n_fail++;
                $display("FAIL b2b_idle%0d: on got %b want 0000", j, voice_on);
            end
        end
        n_checks++;
        if (held !== m_held_vec()) begin
            n_fail++;
            $display("FAIL b2b_held: got %b want %b", held, m_held_vec());
        end
    endtask

    task automatic test_random();
        logic [23:0] ev;
        logic [7:0]  st, d2;
        for (int n = 0; n < 40; n++) begin
            do begin
                st = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'h90;
                d2 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 127));
                ev = {st, 8'(8'h3C + $urandom_range(0, 5)), d2};
            end while (ev == midi_event);
            do_note(ev, 4'($urandom_range(0, 15)), "random");
        end
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        midi_event = 24'h904870;
        act = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({voice_on, voice_off, v_pitch, v_vel, held, ctrl_event, ctrl_valid, steal, drop} !== '0) begin
            n_fail++;
            $display("FAIL mid_scan_reset: outputs got %h want 0",
                     {voice_on, voice_off, v_pitch, v_vel, held, ctrl_event, ctrl_valid, steal, drop});
        end
        midi_event = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            n_checks++;
            if (voice_on !== '0 || held !== '0) begin
                n_fail++;
                $display("FAIL after_reset%0d: on %b held %b want 0", j, voice_on, held);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_note();
        test_note_off();
        test_steal();
        test_ctrl();
        test_back_to_back();
        test_random();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/voice_alloc.md
Name: voice_alloc

Overview:
- Polyphonic voice scheduler between the MIDI receiver and a bank of NUM_VOICES single-voice synth/envelope channels.
- Decodes the incoming MIDI event word and assigns each NOTE_ON to a voice: retrigger, else free voice, else steal.
- Routes each NOTE_OFF to the voice(s) holding that pitch.
- Forwards non-note events (CC, pitch bend) unchanged to the shared control path.

Parameters:
- NUM_VOICES, 4, number of voices scheduled (2..16).
- AGE_BITS, 8, width of the per-voice saturating age counter used for steal selection.

Ports:
- clk_in  input  1  system clock (98.3MHz)
- rst_n_in  input  1  asynchronous, active-low reset
- midi_event  input  MIDI_BYTES  packed event: [23:16] status, [15:8] data1, [7:0] data2
- voice_active_in  input  NUM_VOICES  voice envelope non-zero (not WAITING)
- voice_on_out  output  NUM_VOICES  one-hot, 1-cycle note-on strobe
- voice_off_out  output  NUM_VOICES  1-cycle note-off strobe; may be multi-hot
- voice_pitch_out  output  8  pitch qualifying the on/off strobes
- voice_vel_out  output  7  velocity qualifying voice_on_out
- held_out  output  NUM_VOICES  per-voice key-held flag
- ctrl_event_out  output  MIDI_BYTES  forwarded non-note event
- ctrl_valid_out  output  1  1-cycle strobe for ctrl_event_out
- steal_out  output  1  1-cycle pulse when a note-on took an active voice
- drop_out  output  1  1-cycle pulse when an event is discarded

Behaviour:
- Reset: all outputs are 0. Per-voice pitch, held and age are cleared. prev_event, skid and FSM (IDLE) are also cleared. Reset asserted mid-scan aborts the scan and discards the pending event.
- New event: midi_event != prev_event. prev_event is registered every cycle.
- Decode: status 0x90 with data2 != 0 is NOTE_ON. Status 0x80, or 0x90 with data2 == 0, is NOTE_OFF. Any other status is a ctrl event.
- Ctrl events bypass the FSM. ctrl_event_out is registered and ctrl_valid_out pulses the cycle after detection. Not affected by FSM state.
- Note events:
  - If the FSM is IDLE, the event is latched into the work register.
  - Otherwise it goes into a 1-entry skid.
  - If the skid is full, the event is dropped and drop_out pulses.
- FSM states: IDLE -> SCAN -> ISSUE -> IDLE.
  - SCAN visits one voice per cycle, index 0..NUM_VOICES-1.
  - ISSUE lasts one cycle.
  - From ISSUE the FSM goes to SCAN directly if the skid is valid; the skid moves into the work register.
- Latency: event detected at cycle t; strobes asserted at cycle t+NUM_VOICES+1 for exactly one cycle.
- NOTE_ON selection, decided during SCAN with strict priority:
  1. Lowest-index voice whose stored pitch equals data1 and is held or active (retrigger).
  2. Else lowest-index voice with voice_active_in=0 and held=0 (free).
  3. Else the voice with maximum age, ties to lowest index (steal, steal_out=1).
- ISSUE for NOTE_ON:
  - Sets voice_on_out[v], voice_pitch_out=data1, voice_vel_out=data2[6:0].
  - Stores pitch, sets held[v]=1, age[v]=0.
  - Every other voice's age increments, saturating at 2^AGE_BITS-1.
- NOTE_OFF: every voice with held=1 and pitch==data1 gets voice_off_out and has held cleared.
  - Ages are unchanged.
  - No match: no strobe, no drop_out.
- voice_active_in is sampled during SCAN. A change after a voice has been visited does not affect the current decision.

Optional Feature:
- Macro: VOICE_STEAL_EN.
- Defined: priority step 3 (steal oldest) is active.
- Undefined:
  - A NOTE_ON with no retrigger or free voice issues no strobe and pulses drop_out in the ISSUE cycle.
  - steal_out is tied to 0.
  - Age counters are not synthesized.

Test Plan:
- Reset then midi_event=0x903C64 -> voice_on_out=0001 at t+5, pitch 0x3C, vel 0x64, held_out=0001.
- Notes 0x3C,0x40,0x43,0x48 on, all voice_active_in=1, then 0x904A50 -> VOICE_STEAL_EN: voice_on_out=0001, steal_out=1. Without the macro: drop_out=1, no strobe.
- 0x903C64 then 0x803C00 -> voice_off_out=0001, held_out=0000. 0x903C00 behaves identically.
- 0xB00140 -> ctrl_valid_out at t+1 with ctrl_event_out=0xB00140, including while the FSM is in SCAN.
- Three note-ons on consecutive changing cycles -> first and second are issued at consecutive ISSUE slots, third sets drop_out.
- Assert rst_n_in during SCAN -> all outputs 0 immediately, no strobe after release, held_out=0.
